// File: rtl/gen_xor_pipe.sv
// Elastic XOR scrambler pipeline: every stage XORs a constant key into the word, the last stage also applies MASK.
// Each stage owns its registers inside its own generate scope; mode 1 words pass through unchanged.
module gen_xor_pipe #(
   parameter int unsigned      WIDTH    = 8,
   parameter int unsigned      STAGES   = 4,
   parameter int unsigned      KEY_BASE = 0,
   parameter logic [WIDTH-1:0] MASK     = {WIDTH{1'b1}},
   parameter int unsigned      CNT_W    = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WIDTH-1:0]          in_data,
   input  logic                      in_mode,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic                      out_mode,
   output logic [CNT_W-1:0]          out_count,
   output logic [STAGES*WIDTH-1:0]   stage_tap
);

   // Truncating the sum to WIDTH bits gives the key modulo 2^WIDTH.
   function automatic logic [WIDTH-1:0] stage_key(input int unsigned idx);
      logic [WIDTH-1:0] k;
      k = WIDTH'(KEY_BASE) + WIDTH'(idx);
      return k;
   endfunction

   function automatic logic [WIDTH-1:0] stage_term(input int unsigned idx);
      logic [WIDTH-1:0] t;
      t = stage_key(idx);
      if (idx == STAGES - 1) t = t ^ MASK;
      return t;
   endfunction

   logic [STAGES-1:0] v_vec;
   logic [STAGES-1:0] m_vec;
   logic [WIDTH-1:0]  d_vec [STAGES];
   logic [STAGES:0]   rdy;

   // A stage can load when it is empty or its successor drains it this cycle.
   always_comb begin
      rdy         = '0;
      rdy[STAGES] = out_ready;
      for (int i = STAGES - 1; i >= 0; i--) begin
         rdy[i] = ~v_vec[i] | rdy[i+1];
      end
   end

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam logic [WIDTH-1:0] TERM = stage_term(gi);

      logic             v_q, v_d;
      logic             m_q, m_d;
      logic [WIDTH-1:0] d_q, d_d;
      logic             src_v;
      logic             src_m;
      logic [WIDTH-1:0] src_d;

      if (gi == 0) begin : g_src_in
         assign src_v = in_valid;
         assign src_m = in_mode;
         assign src_d = in_data;
      end else begin : g_src_prev
         assign src_v = v_vec[gi-1];
         assign src_m = m_vec[gi-1];
         assign src_d = d_vec[gi-1];
      end

      always_comb begin
         v_d = v_q;
         m_d = m_q;
         d_d = d_q;
         if (rdy[gi]) begin
            v_d = src_v;
            if (src_v) begin
               d_d = src_m ? src_d : (src_d ^ TERM);
               m_d = src_m;
            end
         end
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            v_q <= 1'b0;
            m_q <= 1'b0;
            d_q <= '0;
         end else begin
            v_q <= v_d;
            m_q <= m_d;
            d_q <= d_d;
         end
      end

      assign v_vec[gi] = v_q;
      assign m_vec[gi] = m_q;
      assign d_vec[gi] = d_q;
   end

   for (genvar ti = 0; ti < STAGES; ti++) begin : g_tap
      assign stage_tap[ti*WIDTH +: WIDTH] = g_stage[ti].d_q;
   end

   assign in_ready  = rdy[0];
   assign out_valid = v_vec[STAGES-1];
   assign out_mode  = m_vec[STAGES-1];
   assign out_data  = d_vec[STAGES-1];

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (out_valid && out_ready) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign out_count = cnt_q;

endmodule

// File: tb/tb_gen_xor_pipe.sv
// Bench for gen_xor_pipe: default, small (W=2,S=2) and keyed (S=3, KEY_BASE=5, CNT_W=3) instances
// checked against a queue model that applies the end-to-end transfer function.
module tb_gen_xor_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic        a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready, a_out_mode;
   logic [7:0]  a_in_data, a_out_data;
   logic [15:0] a_out_count;
   logic [31:0] a_tap;

   logic        b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_out_mode;
   logic [1:0]  b_in_data, b_out_data;
   logic [15:0] b_out_count;
   logic [3:0]  b_tap;

   logic        c_in_valid, c_in_ready, c_in_mode, c_out_valid, c_out_ready, c_out_mode;
   logic [7:0]  c_in_data, c_out_data;
   logic [2:0]  c_out_count;
   logic [23:0] c_tap;

   gen_xor_pipe dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .in_mode(a_in_mode), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .out_mode(a_out_mode), .out_count(a_out_count), .stage_tap(a_tap));

   gen_xor_pipe #(.WIDTH(2), .STAGES(2), .KEY_BASE(0), .MASK(2'b11), .CNT_W(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .in_mode(b_in_mode), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .out_mode(b_out_mode), .out_count(b_out_count), .stage_tap(b_tap));

   gen_xor_pipe #(.WIDTH(8), .STAGES(3), .KEY_BASE(5), .MASK(8'h96), .CNT_W(3)) dut_c (
      .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
      .in_mode(c_in_mode), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
      .out_mode(c_out_mode), .out_count(c_out_count), .stage_tap(c_tap));

   int n_checks = 0;
   int n_fail   = 0;
   int a_exp_cnt = 0;
   int c_exp_cnt = 0;
   logic [8:0] qa[$];
   logic [8:0] qc[$];

   // End-to-end reference: scramble = data ^ MASK ^ (xor of all stage keys), bypass = data.
   function automatic logic [7:0] xform(input int w, input int s, input int kb, input int mask,
                                        input logic [7:0] d, input logic m);
      int t;
      t = mask;
      for (int i = 0; i < s; i++) t = t ^ ((kb + i) % (1 << w));
      return m ? d : (d ^ 8'(t));
   endfunction

   task automatic idle_all();
      a_in_valid = 0; a_in_data = '0; a_in_mode = 0; a_out_ready = 1;
      b_in_valid = 0; b_in_data = '0; b_in_mode = 0; b_out_ready = 1;
      c_in_valid = 0; c_in_data = '0; c_in_mode = 0; c_out_ready = 1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 0;
      idle_all();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      a_out_ready = 0;
      #1;
      n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", a_out_valid); end
      n_checks++; if (a_out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got=%h exp=00", a_out_data); end
      n_checks++; if (a_out_mode !== 1'b0) begin n_fail++; $display("FAIL reset_out_mode got=%b exp=0", a_out_mode); end
      n_checks++; if (a_out_count !== 16'd0) begin n_fail++; $display("FAIL reset_out_count got=%0d exp=0", a_out_count); end
      n_checks++; if (a_tap !== 32'd0) begin n_fail++; $display("FAIL reset_tap got=%h exp=0", a_tap); end
      n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", a_in_ready); end
      n_checks++; if (b_tap !== 4'd0 || c_tap !== 24'd0) begin n_fail++; $display("FAIL reset_taps_bc got=%h/%h exp=0", b_tap, c_tap); end
      a_out_ready = 1;
      a_exp_cnt = 0; c_exp_cnt = 0;
      qa.delete(); qc.delete();
   endtask

   task automatic test_latency();
      logic [7:0] words [3];
      logic [7:0] expv [3];
      int acc_cyc [3];
      int sent = 0, got = 0;
      words = '{8'h5A, 8'h00, 8'hFF};
      expv  = '{8'hA5, 8'hFF, 8'h00};
      for (int c = 0; c < 20 && got < 3; c++) begin
         @(negedge clk);
         a_out_ready = 1; a_in_mode = 0;
         a_in_valid = (sent < 3);
         a_in_data = (sent < 3) ? words[sent] : 8'h00;
         #1;
         if (a_out_valid && a_out_ready) begin
            n_checks++;
            if (got >= 3) begin n_fail++; $display("FAIL latency_extra_word got=%h exp=none", a_out_data); end
            else begin
               if (a_out_data !== expv[got]) begin n_fail++; $display("FAIL latency_data[%0d] got=%h exp=%h", got, a_out_data, expv[got]); end
               n_checks++;
               if (c != acc_cyc[got] + 4) begin n_fail++; $display("FAIL latency_cycle[%0d] got=%0d exp=%0d", got, c, acc_cyc[got] + 4); end
            end
            got++; a_exp_cnt++;
         end
         if (a_in_valid && a_in_ready) begin acc_cyc[sent] = c; sent++; end
      end
      @(negedge clk);
      a_in_valid = 0;
      #1;
      n_checks++; if (got != 3) begin n_fail++; $display("FAIL latency_words_out got=%0d exp=3", got); end
      n_checks++; if (a_out_count !== 16'(a_exp_cnt)) begin n_fail++; $display("FAIL latency_count got=%0d exp=%0d", a_out_count, a_exp_cnt); end
   endtask

   task automatic test_small();
      for (int w = 0; w < 2; w++) begin
         for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            b_out_ready = 1; b_in_mode = 0;
            b_in_valid = (c == 0);
            b_in_data = 2'(w);
            #1;
            if (c == 1) begin
               n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL small_early_valid[%0d] got=%b exp=0", w, b_out_valid); end
            end
            if (c == 2) begin
               n_checks++; if (b_out_valid !== 1'b1) begin n_fail++; $display("FAIL small_valid[%0d] got=%b exp=1", w, b_out_valid); end
               n_checks++; if (b_out_data !== (w == 0 ? 2'd2 : 2'd3)) begin n_fail++; $display("FAIL small_data[%0d] got=%0d exp=%0d", w, b_out_data, (w == 0 ? 2 : 3)); end
               n_checks++; if (b_tap !== (w == 0 ? 4'h8 : 4'hD)) begin n_fail++; $display("FAIL small_tap[%0d] got=%h exp=%h", w, b_tap, (w == 0 ? 4'h8 : 4'hD)); end
            end
         end
      end
   endtask

   task automatic test_bypass();
      logic [7:0] words [3];
      logic       modes [3];
      int sent = 0, got = 0;
      words = '{8'h11, 8'h3C, 8'hC3};
      modes = '{1'b0, 1'b1, 1'b0};
      for (int c = 0; c < 20 && got < 3; c++) begin
         @(negedge clk);
         a_out_ready = 1;
         a_in_valid = (sent < 3);
         a_in_data = (sent < 3) ? words[sent] : 8'h00;
         a_in_mode = (sent < 3) ? modes[sent] : 1'b0;
         #1;
         if (a_out_valid && a_out_ready) begin
            n_checks++;
            if (qa.size() == 0) begin n_fail++; $display("FAIL bypass_unexpected got=%h exp=none", a_out_data); end
            else begin
               if ({a_out_mode, a_out_data} !== qa[0]) begin n_fail++; $display("FAIL bypass_word[%0d] got=%b/%h exp=%b/%h", got, a_out_mode, a_out_data, qa[0][8], qa[0][7:0]); end
               void'(qa.pop_front());
            end
            got++; a_exp_cnt++;
         end
         if (a_in_valid && a_in_ready) begin
            qa.push_back({a_in_mode, xform(8, 4, 0, 255, a_in_data, a_in_mode)});
            sent++;
         end
      end
      n_checks++; if (got != 3) begin n_fail++; $display("FAIL bypass_words_out got=%0d exp=3", got); end
   endtask

   task automatic test_backpressure();
      logic [7:0] words [6];
      int sent = 0, got = 0;
      for (int i = 0; i < 6; i++) words[i] = 8'($urandom);
      for (int c = 0; c < 60 && got < 6; c++) begin
         @(negedge clk);
         a_out_ready = (c >= 10);
         a_in_mode = 0;
         a_in_valid = (sent < 6);
         a_in_data = (sent < 6) ? words[sent] : 8'h00;
         #1;
         if (c == 9) begin
            n_checks++; if (sent != 4) begin n_fail++; $display("FAIL bp_accepted got=%0d exp=4", sent); end
            n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got=%b exp=0", a_in_ready); end
         end
         if (a_out_valid) begin
            n_checks++;
            if (qa.size() == 0) begin n_fail++; $display("FAIL bp_unexpected got=%h exp=none", a_out_data); end
            else begin
               if ({a_out_mode, a_out_data} !== qa[0]) begin n_fail++; $display("FAIL bp_word[%0d] cyc=%0d got=%h exp=%h", got, c, a_out_data, qa[0][7:0]); end
               if (a_out_ready) begin void'(qa.pop_front()); got++; a_exp_cnt++; end
            end
         end
         if (a_in_valid && a_in_ready) begin
            qa.push_back({1'b0, xform(8, 4, 0, 255, a_in_data, 1'b0)});
            sent++;
         end
      end
      @(negedge clk);
      a_in_valid = 0; a_out_ready = 1;
      #1;
      n_checks++; if (got != 6 || qa.size() != 0) begin n_fail++; $display("FAIL bp_drain got=%0d left=%0d exp=6/0", got, qa.size()); end
      n_checks++; if (a_out_count !== 16'(a_exp_cnt)) begin n_fail++; $display("FAIL bp_count got=%0d exp=%0d", a_out_count, a_exp_cnt); end
   endtask

   task automatic test_reset_mid();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         a_out_ready = 1; a_in_valid = 1; a_in_mode = 0; a_in_data = 8'($urandom);
      end
      @(negedge clk);
      a_in_valid = 0;
      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
      #1;
      qa.delete(); a_exp_cnt = 0; c_exp_cnt = 0; qc.delete();
      n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid got=%b exp=0", a_out_valid); end
      n_checks++; if (a_out_count !== 16'd0) begin n_fail++; $display("FAIL rmid_count got=%0d exp=0", a_out_count); end
      n_checks++; if (a_tap !== 32'd0) begin n_fail++; $display("FAIL rmid_tap got=%h exp=0", a_tap); end
      n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready got=%b exp=1", a_in_ready); end
      for (int c = 0; c < 8; c++) begin
         if (c > 0) @(negedge clk);
         a_in_valid = (c == 0); a_in_data = 8'h77; a_in_mode = 0;
         #1;
         n_checks++;
         if (a_out_valid !== (c == 4)) begin n_fail++; $display("FAIL rmid_valid cyc=%0d got=%b exp=%b", c, a_out_valid, (c == 4)); end
         if (c == 4) begin
            n_checks++; if (a_out_data !== 8'h88) begin n_fail++; $display("FAIL rmid_data got=%h exp=88", a_out_data); end
            a_exp_cnt++;
         end
      end
      n_checks++; if (a_out_count !== 16'(a_exp_cnt)) begin n_fail++; $display("FAIL rmid_count_after got=%0d exp=%0d", a_out_count, a_exp_cnt); end
   endtask

   task automatic test_count_wrap();
      int sent = 0, got = 0;
      logic [2:0] e;
      for (int c = 0; c < 40 && got < 9; c++) begin
         @(negedge clk);
         c_out_ready = 1; c_in_mode = 0;
         c_in_valid = (sent < 9);
         c_in_data = 8'($urandom);
         #1;
         if (c_out_valid && c_out_ready) begin
            n_checks++;
            if (qc.size() == 0) begin n_fail++; $display("FAIL wrap_unexpected got=%h exp=none", c_out_data); end
            else begin
               if ({c_out_mode, c_out_data} !== qc[0]) begin n_fail++; $display("FAIL wrap_word[%0d] got=%h exp=%h", got, c_out_data, qc[0][7:0]); end
               void'(qc.pop_front());
            end
            got++; c_exp_cnt++;
         end
         if (c_in_valid && c_in_ready) begin
            qc.push_back({1'b0, xform(8, 3, 5, 8'h96, c_in_data, 1'b0)});
            sent++;
         end
      end
      @(negedge clk);
      c_in_valid = 0;
      #1;
      e = 3'd1;
      n_checks++; if (got != 9) begin n_fail++; $display("FAIL wrap_words_out got=%0d exp=9", got); end
      n_checks++; if (c_out_count !== e) begin n_fail++; $display("FAIL wrap_count got=%0d exp=%0d", c_out_count, e); end
   endtask

   task automatic test_random();
      logic [31:0] ec;
      for (int c = 0; c < 420; c++) begin
         @(negedge clk);
         if (c < 400) begin
            c_in_valid = ($urandom % 4) != 0;
            c_in_data = 8'($urandom);
            c_in_mode = ($urandom % 4) == 0;
            c_out_ready = ($urandom % 3) != 0;
         end else begin
            c_in_valid = 0; c_out_ready = 1;
         end
         #1;
         ec = 32'(c_exp_cnt);
         n_checks++; if (c_out_count !== ec[2:0]) begin n_fail++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", c, c_out_count, ec[2:0]); end
         if (c_out_valid && c_out_ready) begin
            n_checks++;
            if (qc.size() == 0) begin n_fail++; $display("FAIL rand_unexpected cyc=%0d got=%h exp=none", c, c_out_data); end
            else begin
               if ({c_out_mode, c_out_data} !== qc[0]) begin n_fail++; $display("FAIL rand_word cyc=%0d got=%b/%h exp=%b/%h", c, c_out_mode, c_out_data, qc[0][8], qc[0][7:0]); end
               void'(qc.pop_front());
            end
            c_exp_cnt++;
         end
         if (c_in_valid && c_in_ready) qc.push_back({c_in_mode, xform(8, 3, 5, 8'h96, c_in_data, c_in_mode)});
      end
      n_checks++; if (qc.size() != 0) begin n_fail++; $display("FAIL rand_drain left=%0d exp=0", qc.size()); end
   endtask

   initial begin
      rst_n = 0;
      idle_all();
      test_reset();
      test_latency();
      test_small();
      test_bypass();
      test_backpressure();
      test_reset_mid();
      test_count_wrap();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
